// File: rtl/alu_md_unit_pkg.sv
// alu_md_unit_pkg: shared opcodes, funct7 groups, decoded op and FSM state types for the EX unit.
package alu_md_unit_pkg;
  localparam logic [1:0] ALUOP_LWSW = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_INVALID
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000: return OP_ADD;
      3'b001: return OP_SLL;
      3'b010: return OP_SLT;
      3'b011: return OP_SLTU;
      3'b100: return OP_XOR;
      3'b101: return OP_SRL;
      3'b110: return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
  // M-group ops are laid out in funct3 order starting at OP_MUL
  function automatic alu_op_e decode(input logic [1:0] aluop, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic en_m);
    if (aluop == ALUOP_LWSW) return OP_ADD;
    if (aluop == ALUOP_BRANCH) return OP_SUB;
    if (aluop == ALUOP_RTYPE)
      return f7 == FUNCT7_BASE ? base_op(f3)
           : f7 == FUNCT7_ALT && f3 == 3'b000 ? OP_SUB
           : f7 == FUNCT7_ALT && f3 == 3'b101 ? OP_SRA
           : f7 == FUNCT7_MULDIV && en_m ? alu_op_e'(5'(OP_MUL) + {2'b00, f3})
           : OP_INVALID;
    return f3 == 3'b001 ? (f7 == FUNCT7_BASE ? OP_SLL : OP_INVALID)
         : f3 == 3'b101 ? (f7 == FUNCT7_BASE ? OP_SRL : f7 == FUNCT7_ALT ? OP_SRA : OP_INVALID)
         : base_op(f3);
  endfunction
  function automatic logic is_md(input alu_op_e op);
    return op >= OP_MUL && op <= OP_REMU;
  endfunction
endpackage

// File: rtl/alu_md_unit_md_iter.sv
// md_iter: XLEN-step shift-add multiplier / restoring divider on magnitudes with sign fix-up.
module md_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic busy, neg, sa_q, dz, sa, sb;
  logic [2:0] op_q;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] mb, quo, rem;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN:0] sum, rem_sh, diff;
  assign sa = (op inside {3'd1, 3'd2, 3'd4, 3'd6}) & a[XLEN-1];
  assign sb = (op inside {3'd1, 3'd4, 3'd6}) & b[XLEN-1];
  // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : '0);
  assign rem_sh = acc[2*XLEN-1:XLEN-1];
  assign diff = rem_sh - {1'b0, mb};
  assign acc_nx = op_q[2] ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                          : {sum, acc[XLEN-1:1]};
  assign prod = neg ? -acc_nx : acc_nx;
  assign quo = dz ? '1 : neg ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem = sa_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
  assign result = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : op_q[1] ? rem : quo;
  assign done = busy && cnt == CW'(XLEN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      op_q <= '0;
      mb <= '0;
      acc <= '0;
      neg <= 1'b0;
      sa_q <= 1'b0;
      dz <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      op_q <= op;
      mb <= sb ? -b : b;
      acc <= {{XLEN{1'b0}}, (sa ? -a : a)};
      neg <= sa ^ sb;
      sa_q <= sa;
      dz <= b == '0;
    end else if (busy) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: EX-stage RV32I ALU with iterative RV32M multiply/divide behind valid/ready handshakes.
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  state_e state, state_nx;
  alu_op_e op;
  logic accept, md_done;
  logic [XLEN-1:0] base_res, md_res;
  logic [SW-1:0] sh;
  assign op = decode(aluop, funct3, funct7, ENABLE_M);
  assign sh = op_b[SW-1:0];
  assign in_ready = state == S_IDLE;
  assign busy = state == S_ITER;
  assign out_valid = state == S_DONE;
  assign accept = in_valid && in_ready && !flush;
  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD: base_res = op_a + op_b;
      OP_SUB: base_res = op_a - op_b;
      OP_SLL: base_res = op_a << sh;
      OP_SLT: base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR: base_res = op_a ^ op_b;
      OP_SRL: base_res = op_a >> sh;
      OP_SRA: base_res = $unsigned($signed(op_a) >>> sh);
      OP_OR: base_res = op_a | op_b;
      OP_AND: base_res = op_a & op_b;
      default: base_res = '0;
    endcase
  end
  if (ENABLE_M) begin : g_md
    md_iter #(.XLEN(XLEN)) u_md (
      .clk(clk), .rst_n(rst_n), .flush(flush), .start(accept && is_md(op)),
      .op(funct3), .a(op_a), .b(op_b), .done(md_done), .result(md_res)
    );
  end else begin : g_nomd
    assign md_done = 1'b0;
    assign md_res = '0;
  end
  always_comb begin
    state_nx = flush ? S_IDLE
             : state == S_IDLE ? (accept ? (is_md(op) ? S_ITER : S_DONE) : S_IDLE)
             : state == S_ITER ? (md_done ? S_DONE : S_ITER)
             : (out_ready ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      result <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !is_md(op)) begin
        result <= base_res;
        illegal <= op == OP_INVALID;
      end else if (state == S_ITER && md_done && !flush) begin
        result <= md_res;
        illegal <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed vectors into a scoreboard queue; a negedge monitor checks latency and results.
module tb_alu_md_unit;
  logic clk = 1'b0, rst_n, flush, in_valid, out_ready;
  logic [1:0] aluop;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] op_a, op_b, result, result1;
  logic in_ready, out_valid, illegal, busy;
  logic in_ready1, out_valid1, illegal1, busy1;
  int pass = 0, total = 0;
  bit seen = 0;
  typedef struct {string name; logic [31:0] res; logic ill; int lat; time t;} exp_t;
  exp_t q[$];
  localparam logic [1:0] RT = 2'b10, IT = 2'b11;
  localparam logic [6:0] F7B = 7'h00, F7A = 7'h20, F7M = 7'h01;

  always #5 clk = ~clk;

  alu_md_unit #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal), .busy(busy)
  );
  alu_md_unit #(.XLEN(32), .ENABLE_M(0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .illegal(illegal1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        if (!seen) chk({q[0].name, "_lat"}, 32'(int'(($time - q[0].t + 5) / 10)), 32'(q[0].lat));
        seen = 1;
        if (out_ready) begin
          chk({q[0].name, "_res"}, result, q[0].res);
          chk({q[0].name, "_ill"}, 32'(illegal), 32'(q[0].ill));
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && q.size() == 0) return;
    end
    chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic ill, input string name, input bit push = 1);
    exp_t e;
    aluop = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1;
    chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    e.name = name; e.res = res; e.ill = ill; e.t = $time;
    e.lat = (!ill && aop == RT && f7 == F7M) ? 33 : 1;
    if (push) q.push_back(e);
    #1 in_valid = 0;
  endtask

  task automatic run(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                     input logic ill, input string name);
    wait_idle();
    issue(aop, f3, f7, a, b, res, ill, name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit vis;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    aluop = 0; funct3 = 0; funct7 = 0; op_a = 0; op_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1;
    // M op on the M-less instance must come back illegal in one cycle
    wait_idle();
    issue(RT, 3'b000, F7M, 32'h3, 32'h5, 32'hF, 0, "mul_small");
    @(negedge clk);
    chk("nom_valid", 32'(out_valid1), 32'd1);
    chk("nom_illegal", 32'(illegal1), 32'd1);
    chk("nom_result", result1, 32'd0);
    run(RT, 3'b000, F7B, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, "add_wrap");
    run(RT, 3'b101, F7A, 32'h80000000, 32'h23, 32'hF0000000, 0, "sra_shamt");
    run(RT, 3'b000, F7A, 32'h5, 32'h7, 32'hFFFFFFFE, 0, "sub");
    run(2'b00, 3'b010, 7'h7F, 32'd10, 32'd20, 32'd30, 0, "lwsw_add");
    run(2'b01, 3'b111, 7'h20, 32'd3, 32'd5, 32'hFFFFFFFE, 0, "branch_sub");
    run(RT, 3'b010, F7B, 32'hFFFFFFFF, 32'h1, 32'h1, 0, "slt");
    run(RT, 3'b011, F7B, 32'hFFFFFFFF, 32'h1, 32'h0, 0, "sltu");
    run(RT, 3'b100, F7B, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, "xor");
    run(RT, 3'b110, F7B, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, "or");
    run(RT, 3'b111, F7B, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, "and");
    run(RT, 3'b001, F7B, 32'h1, 32'h21, 32'h2, 0, "sll");
    run(RT, 3'b101, F7B, 32'h80000000, 32'h4, 32'h08000000, 0, "srl");
    run(IT, 3'b000, 7'h55, 32'd100, 32'hFFFFFFFF, 32'd99, 0, "addi");
    run(IT, 3'b101, F7A, 32'h80000000, 32'h1, 32'hC0000000, 0, "srai");
    run(IT, 3'b101, F7B, 32'h80000000, 32'h1, 32'h40000000, 0, "srli");
    run(IT, 3'b001, F7A, 32'h1, 32'h1, 32'h0, 1, "slli_bad");
    run(IT, 3'b101, 7'h01, 32'h1, 32'h1, 32'h0, 1, "srxi_bad");
    run(RT, 3'b001, F7A, 32'h1, 32'h1, 32'h0, 1, "rt_alt_bad");
    run(RT, 3'b000, 7'h7F, 32'h1, 32'h1, 32'h0, 1, "rt_f7_bad");
    run(RT, 3'b001, F7M, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min");
    run(RT, 3'b010, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu");
    run(RT, 3'b011, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
    run(RT, 3'b000, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "mul_ones");
    run(RT, 3'b000, F7M, 32'h00012345, 32'h100, 32'h01234500, 0, "mul_shift");
    run(RT, 3'b001, F7M, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 0, "mulh_neg");
    run(RT, 3'b000, F7M, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 0, "mul_neg");
    run(RT, 3'b110, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem_neg");
    run(RT, 3'b101, F7M, 32'd7, 32'd0, 32'hFFFFFFFF, 0, "divu_zero");
    run(RT, 3'b110, F7M, 32'd7, 32'd0, 32'd7, 0, "rem_zero");
    run(RT, 3'b100, F7M, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 0, "div_neg_zero");
    run(RT, 3'b100, F7M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
    run(RT, 3'b110, F7M, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, "rem_ovf");
    run(RT, 3'b111, F7M, 32'd20, 32'd6, 32'd2, 0, "remu");
    run(RT, 3'b101, F7M, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 0, "divu");
    // busy window of a divide: cycles 1..32 after accept
    run(RT, 3'b100, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div_neg");
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      chk($sformatf("div_busy_c%0d", i), 32'(busy), 32'(i <= 32));
    end
    // flush mid-divide with a competing request
    wait_idle();
    issue(RT, 3'b100, F7M, 32'd100, 32'd3, 32'd0, 0, "div_flush", 0);
    repeat (9) @(posedge clk);
    #1 flush = 1; in_valid = 1; aluop = RT; funct3 = 3'b000; funct7 = F7B;
    @(posedge clk);
    #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    vis = 0;
    repeat (40) begin
      @(negedge clk);
      vis |= out_valid;
    end
    chk("flush_no_output", 32'(vis), 32'd0);
    // asynchronous reset mid-divide
    wait_idle();
    issue(RT, 3'b100, F7M, 32'd100, 32'd3, 32'd0, 0, "div_reset", 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #2 rst_n = 1;
    run(RT, 3'b000, F7B, 32'd1, 32'd1, 32'd2, 0, "add_after_rst");
    // output backpressure: DONE holds and ignores new requests
    wait_idle();
    out_ready = 0;
    issue(RT, 3'b000, F7B, 32'd3, 32'd4, 32'd7, 0, "add_hold");
    in_valid = 1; op_a = 32'd100; op_b = 32'd200;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_res_c%0d", i), result, 32'd7);
      chk($sformatf("hold_rdy_c%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("hold_valid_c%0d", i), 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 0; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    issue(RT, 3'b000, F7B, 32'd100, 32'd200, 32'd300, 0, "add_next");
    wait_idle();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
